in_port_controller: RTL and testbench

- Inbound peripheral-to-core path. It is the receive-side counterpart of the processor's OUT path.
- An external device pushes 16-bit words over a valid/ready handshake. Words are buffered in a small FIFO, and the head word is presented on input_port for the IN instruction.
- The block raises interrupt_signal to the processor when new data arrives. Sits beside the processor top, driving its input_port and interrupt_signal.

---
 rtl/in_port_if.sv | 30 +++
 rtl/in_port_controller.sv | 144 ++++++++++++++
 tb/tb_in_port_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/in_port_if.sv
// Handshake/bus bundle between an external device, the inbound port controller and the core.
// The slave side is the controller; the master side is whoever drives the device and the core.
interface in_port_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              dev_valid;
  logic [DATA_W-1:0] dev_data;
  logic              dev_ready;
  logic              in_read;
  logic [DATA_W-1:0] input_port;
  logic              input_valid;
  logic              interrupt_signal;
  logic              irq_ack;
  logic              clr_ovf;
  logic              overflow;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  dev_valid, dev_data, in_read, irq_ack, clr_ovf,
    output dev_ready, input_port, input_valid, interrupt_signal, overflow, fifo_count
  );

  modport master (
    output dev_valid, dev_data, in_read, irq_ack, clr_ovf,
    input  dev_ready, input_port, input_valid, interrupt_signal, overflow, fifo_count
  );
endinterface

// File: rtl/in_port_controller.sv
// Inbound device-to-core port: small FIFO feeding input_port plus an interrupt generator.
// Define INPORT_LEVEL_IRQ_EN for a level interrupt; default build uses a rate-limited pulse.
module in_port_controller #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int IRQ_HOLDOFF = 8
) (
  input  logic     clk,
  input  logic     rst,
  in_port_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.dev_valid && !full;
  assign pop   = bus.in_read && !empty;

  assign bus.dev_ready   = !full;
  assign bus.input_valid = !empty;
  assign bus.input_port  = empty ? '0 : mem[rd_ptr];
  assign bus.overflow    = ovf_q;
  assign bus.fifo_count  = count;

  // Storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.dev_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A refused offer outranks a clear issued in the same cycle.
      if (bus.dev_valid && full) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef INPORT_LEVEL_IRQ_EN
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } irq_state_t;

  irq_state_t state;

  // Request stays up while data waits, muted once the core has acknowledged.
  assign bus.interrupt_signal = !empty && (state != DRAIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.irq_ack) state <= DRAIN;
        DRAIN:   if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  localparam int HO_W = $clog2(IRQ_HOLDOFF + 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2,
    DRAIN    = 2'd3
  } irq_state_t;

  irq_state_t       state;
  logic [HO_W-1:0]  holdoff;
  logic             irq_q;

  function automatic logic [HO_W-1:0] sat_dec(input logic [HO_W-1:0] v);
    return (v == '0) ? v : v - HO_W'(1);
  endfunction

  assign bus.interrupt_signal = irq_q;

  // Holdoff runs down in every state; only the ASSERT cycle reloads it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      holdoff <= '0;
      irq_q   <= 1'b0;
    end else begin
      holdoff <= sat_dec(holdoff);
      irq_q   <= 1'b0;
      case (state)
        IDLE: begin
          if ((push || !empty) && (holdoff == '0)) begin
            state <= ASSERT;
            irq_q <= 1'b1;
          end
        end
        ASSERT: begin
          holdoff <= HO_W'(IRQ_HOLDOFF);
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.irq_ack) state <= DRAIN;
        end
        DRAIN: begin
          if (empty && (holdoff == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_in_port_controller.sv
// Bench for in_port_controller (pulse-interrupt build): directed scenarios then random traffic,
// all checked each cycle against a queue-based model that tracks interrupts by timestamps.
module tb_in_port_controller;
  localparam int DATA_W      = 16;
  localparam int DEPTH       = 4;
  localparam int IRQ_HOLDOFF = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  in_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  in_port_controller #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .IRQ_HOLDOFF(IRQ_HOLDOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model
  logic [DATA_W-1:0] q[$];
  bit m_ovf;
  bit m_pulse;
  bit m_need_ack;
  bit m_drain;
  int last_pulse = -1000;
  int irq_times[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rn, input bit dv, input logic [DATA_W-1:0] dd,
                      input bit rd, input bit ack, input bit clr);
    bit full, was_empty, push, pop, hold_clear;
    rst           = rn;
    bus.dev_valid = dv;
    bus.dev_data  = dd;
    bus.in_read   = rd;
    bus.irq_ack   = ack;
    bus.clr_ovf   = clr;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      q.delete();
      m_ovf      = 1'b0;
      m_pulse    = 1'b0;
      m_need_ack = 1'b0;
      m_drain    = 1'b0;
      last_pulse = -1000;
    end else begin
      full       = (q.size() == DEPTH);
      was_empty  = (q.size() == 0);
      push       = dv && !full;
      pop        = rd && !was_empty;
      hold_clear = (cyc >= last_pulse + IRQ_HOLDOFF + 2);
      if (m_pulse) begin
        m_pulse    = 1'b0;
        m_need_ack = 1'b1;
        last_pulse = cyc - 1;
      end else if (m_need_ack) begin
        if (ack) begin
          m_need_ack = 1'b0;
          m_drain    = 1'b1;
        end
      end else if (m_drain) begin
        if (was_empty && hold_clear) m_drain = 1'b0;
      end else if ((push || !was_empty) && hold_clear) begin
        m_pulse = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(dd);
      if (dv && full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    chk("fifo_count", bus.fifo_count, q.size());
    chk("dev_ready", bus.dev_ready, (q.size() != DEPTH));
    chk("input_valid", bus.input_valid, (q.size() != 0));
    chk("input_port", bus.input_port, (q.size() != 0) ? q[0] : '0);
    chk("interrupt", bus.interrupt_signal, m_pulse);
    chk("overflow", bus.overflow, m_ovf);
    if (bus.interrupt_signal) irq_times.push_back(cyc);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic idle();
    step(1, 0, '0, 0, 0, 0);
  endtask

  initial begin
    int first, second, npulse;
    bit seen;

    do_reset();
    chk("rst_ready", bus.dev_ready, 1);
    chk("rst_valid", bus.input_valid, 0);
    chk("rst_port", bus.input_port, 0);
    chk("rst_irq", bus.interrupt_signal, 0);

    // Single word: 1-cycle latency and a single-cycle pulse
    step(1, 1, 16'hBEEF, 0, 0, 0);
    chk("t1_port", bus.input_port, 16'hBEEF);
    chk("t1_count", bus.fifo_count, 1);
    chk("t1_irq_on", bus.interrupt_signal, 1);
    idle();
    chk("t1_irq_off", bus.interrupt_signal, 0);

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 1, DATA_W'(i), 0, 0, 0);
    chk("t2_full_count", bus.fifo_count, 4);
    chk("t2_full_ready", bus.dev_ready, 0);
    step(1, 1, 16'h0005, 0, 0, 0);
    chk("t2_ovf", bus.overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_head", bus.input_port, i);
      step(1, 0, '0, 1, 0, 0);
    end
    chk("t2_empty_port", bus.input_port, 0);
    step(1, 0, '0, 0, 0, 1);
    chk("t2_ovf_clr", bus.overflow, 0);

    // Full: pop wins the cycle, refused word is retaken next cycle
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 1, DATA_W'(i), 0, 0, 0);
    step(1, 1, 16'h00AA, 1, 0, 0);
    chk("t3_count_after_pop", bus.fifo_count, 3);
    chk("t3_head", bus.input_port, 2);
    step(1, 1, 16'h00AA, 0, 0, 0);
    chk("t3_count_refill", bus.fifo_count, 4);

    // Interrupt holdoff spacing
    do_reset();
    npulse = irq_times.size();
    step(1, 1, 16'h000A, 0, 0, 0);
    first = cyc;
    idle();
    step(1, 1, 16'h000B, 1, 1, 0);
    step(1, 0, '0, 1, 0, 0);
    repeat (12) idle();
    chk("t4_no_early_pulse", irq_times.size() - npulse, 1);
    step(1, 1, 16'h000C, 0, 0, 0);
    seen = bus.interrupt_signal;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle();
      seen = bus.interrupt_signal;
    end
    second = cyc;
    chk("t4_second_pulse_seen", seen, 1);
    chk("t4_gap_ge_holdoff", (second - first) >= IRQ_HOLDOFF, 1);

    // Pointer wrap with push/pop pairs
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, DATA_W'(16'h0100 + i), 0, 0, 0);
      chk("t5_head", bus.input_port, 16'h0100 + i);
      chk("t5_count", bus.fifo_count, 1);
      step(1, 0, '0, 1, 0, 0);
    end

    // Reset mid-transfer with words buffered and an unacknowledged interrupt
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, DATA_W'(16'h0200 + i), 0, 0, 0);
    idle();
    step(0, 0, '0, 0, 0, 0);
    chk("t6_count", bus.fifo_count, 0);
    chk("t6_port", bus.input_port, 0);
    chk("t6_irq", bus.interrupt_signal, 0);
    chk("t6_ovf", bus.overflow, 0);

    // Random traffic with shifting read pressure
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit rd_heavy;
      rd_heavy = ((n / 200) % 2) == 1;
      step($urandom_range(0, 249) != 0,
           $urandom_range(0, 2) != 0,
           DATA_W'($urandom),
           rd_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
